uart_rx_param: RTL and testbench

//   Parametrised UART receiver; successor to the fixed 8N1, 16x receiver.

---
 rtl/uart_rx_param_if.sv | 21 ++
 rtl/uart_rx_param.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Received-word handshake between uart_rx_param (master) and its consumer (slave).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output out, out_valid, parity_err, frame_err, overrun,
    input  out_ready
  );

  modport slave (
    input  out, out_valid, parity_err, frame_err, overrun,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, 3-sample mid-bit vote, word ready one clk after the last stop sample.
// Backpressure: a one-word holding register; a word completing while it is still full is dropped with an overrun pulse.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in,
  output logic            busy,
  uart_rx_param_if.master rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic HAS_PARITY = (PARITY != 0);
  localparam logic ODD_PARITY = (PARITY == 2);
  localparam logic STOP_LAST  = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 in_sample;
  logic [2:0]           hist;
  logic                 vote;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] word;
  logic                 p_bad;
  logic                 f_bad;
  logic                 done;

  logic [DATA_BITS-1:0] out_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;

  assign in_sample = sync[1];
  assign vote      = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign tick      = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      hist <= 3'b111;
    end else begin
      sync <= {sync[0], in};
      hist <= {hist[1:0], in_sample};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      word     <= '0;
      p_bad    <= 1'b0;
      f_bad    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        armed    <= 1'b0;
        cnt      <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (state != IDLE) cnt <= tick ? '0 : cnt + 1'b1;
        case (state)
          IDLE: begin
            // Start needs a high line first, so a stuck-low line never retriggers.
            if (in_sample) begin
              armed <= 1'b1;
              cnt   <= '0;
            end else if (armed) begin
              if (cnt == CNT_HALF) begin
                state   <= START;
                cnt     <= '0;
                busy    <= 1'b1;
                bit_idx <= '0;
                p_bad   <= 1'b0;
                f_bad   <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          START: begin
            // The baud counted from the start-bit centre ends on data bit 0's centre.
            if (tick) begin
              word    <= {vote, word[DATA_BITS-1:1]};
              bit_idx <= BW'(1);
              state   <= DATA;
            end
          end
          DATA: begin
            if (tick) begin
              word <= {vote, word[DATA_BITS-1:1]};
              if (bit_idx == IDX_LAST) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                state    <= HAS_PARITY ? PAR : STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          PAR: begin
            if (tick) begin
              p_bad    <= ((^word) ^ vote) != ODD_PARITY;
              stop_idx <= 1'b0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (tick) begin
              f_bad <= f_bad | ~vote;
              if (stop_idx == STOP_LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                armed <= 1'b0;
                state <= IDLE;
              end else begin
                stop_idx <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // word/p_bad/f_bad are stable during the done cycle: a new start needs re-arming first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!valid_q || rx.out_ready) begin
          out_q   <= word;
          perr_q  <= p_bad;
          ferr_q  <= f_bad;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.out        = out_q;
  assign rx.out_valid  = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + random frames into three receiver configurations, checked against a frame-level model.
module tb_uart_rx_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en;
  logic line_a, line_b, line_c;
  logic busy_a, busy_b, busy_c;
  int   checks = 0;
  int   fails = 0;
  int   busy_cyc = 0;
  int   ovr_a = 0;
  logic last_pbit = 1'b0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  logic [10:0] q_c[$];

  // Config per receiver: a = 8N1/16x, b = 8E1/16x, c = 7O2/8x
  int NB[3] = '{8, 8, 7};
  int OS[3] = '{16, 16, 8};
  int PM[3] = '{0, 1, 2};
  int NS[3] = '{1, 1, 2};

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7)) if_c ();

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in(line_a), .busy(busy_a), .rx(if_a));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in(line_b), .busy(busy_b), .rx(if_b));
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .in(line_c), .busy(busy_c), .rx(if_c));

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_a.out_valid && if_a.out_ready) q_a.push_back({if_a.frame_err, if_a.parity_err, 1'b0, if_a.out});
      if (if_b.out_valid && if_b.out_ready) q_b.push_back({if_b.frame_err, if_b.parity_err, 1'b0, if_b.out});
      if (if_c.out_valid && if_c.out_ready) q_c.push_back({if_c.frame_err, if_c.parity_err, 2'b00, if_c.out});
      if (if_a.overrun) ovr_a++;
      if (busy_a) busy_cyc++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int k, input logic v);
    case (k)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  task automatic hold(input int k, input logic v, input int n);
    set_line(k, v);
    tick(n);
  endtask

  function automatic logic [8:0] mask(input int k);
    return 9'((1 << NB[k]) - 1);
  endfunction

  // force_p < 0 sends the correct parity bit for the mode, else the given bit
  task automatic send(input int k, input logic [8:0] d, input int force_p = -1,
                      input bit stop_low = 1'b0, input int spike = -1);
    int os;
    os = OS[k];
    hold(k, 1'b0, os);
    for (int i = 0; i < NB[k]; i++) begin
      if (i == spike && d[i]) begin
        hold(k, 1'b1, os / 2);
        hold(k, 1'b0, 1);
        hold(k, 1'b1, os - os / 2 - 1);
      end else begin
        hold(k, d[i], os);
      end
    end
    if (PM[k] != 0) begin
      int ones;
      ones = $countones(d & mask(k));
      if (force_p >= 0) last_pbit = force_p[0];
      else last_pbit = (PM[k] == 1) ? ones[0] : ~ones[0];
      hold(k, last_pbit, os);
    end
    for (int s = 0; s < NS[k]; s++) hold(k, !(stop_low && s == NS[k] - 1), os);
  endtask

  // Expected {frame_err, parity_err, data}: parity is bad when the total count of
  // ones (data + parity bit) is odd for even mode, or even for odd mode.
  function automatic logic [10:0] model(input int k, input logic [8:0] d, input logic pbit,
                                        input bit stop_low);
    logic [8:0] dm;
    logic perr;
    int total;
    dm = d & mask(k);
    perr = 1'b0;
    if (PM[k] != 0) begin
      total = $countones(dm) + int'(pbit);
      perr = ((total % 2) == 1) != (PM[k] == 2);
    end
    return {stop_low, perr, dm};
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic expect_word(input int k, input logic [10:0] exp, input string tag);
    logic [10:0] got;
    int n;
    n = 0;
    while (qsize(k) == 0 && n < 64 * OS[k]) begin
      tick();
      n++;
    end
    chk({tag, "_avail"}, 32'(qsize(k) > 0), 32'd1);
    if (qsize(k) > 0) begin
      case (k)
        0:       got = q_a.pop_front();
        1:       got = q_b.pop_front();
        default: got = q_c.pop_front();
      endcase
      chk(tag, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    logic [8:0] d, d2;
    int fp;
    rst_n = 1'b0;
    en = 1'b1;
    line_a = 1'b1;
    line_b = 1'b1;
    line_c = 1'b1;
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    if_c.out_ready = 1'b1;
    tick(3);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_out", 32'(if_a.out), 32'd0);
    chk("rst_flags", 32'({if_a.parity_err, if_a.frame_err, if_a.overrun}), 32'd0);
    rst_n = 1'b1;
    tick(40);

    // 8N1 0xA5, busy about nine baud
    busy_cyc = 0;
    send(0, 9'h0A5);
    tick(10);
    expect_word(0, model(0, 9'h0A5, 1'b0, 1'b0), "a5");
    chk("a5_single_pulse", 32'(q_a.size()), 32'd0);
    chk("a5_busy_len", 32'(busy_cyc >= 136 && busy_cyc <= 160), 32'd1);

    for (int i = 0; i < 6; i++) begin
      d = 9'($urandom_range(0, 255));
      send(0, d);
      expect_word(0, model(0, d, 1'b0, 1'b0), "a_rand");
    end

    // back-to-back frames
    d = 9'($urandom_range(0, 255));
    d2 = 9'($urandom_range(0, 255));
    send(0, d);
    send(0, d2);
    expect_word(0, model(0, d, 1'b0, 1'b0), "b2b_first");
    expect_word(0, model(0, d2, 1'b0, 1'b0), "b2b_second");

    // single-tick low spike at data bit 3 centre
    d = 9'($urandom_range(0, 255)) | 9'h008;
    send(0, d, -1, 1'b0, 3);
    expect_word(0, model(0, d, 1'b0, 1'b0), "spike");

    // stop bit low, line stays low: no restart
    send(0, 9'h05A, -1, 1'b1);
    expect_word(0, model(0, 9'h05A, 1'b0, 1'b1), "stop_low");
    busy_cyc = 0;
    hold(0, 1'b0, 48);
    chk("stuck_low_busy", 32'(busy_cyc), 32'd0);
    hold(0, 1'b1, 32);

    // short low glitch
    busy_cyc = 0;
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 40);
    chk("glitch_busy", 32'(busy_cyc), 32'd0);
    chk("glitch_word", 32'(q_a.size()), 32'd0);

    // even parity
    send(1, 9'h003, 1);
    expect_word(1, model(1, 9'h003, last_pbit, 1'b0), "par_bad");
    send(1, 9'h003, 0);
    expect_word(1, model(1, 9'h003, last_pbit, 1'b0), "par_ok");
    for (int i = 0; i < 5; i++) begin
      d = 9'($urandom_range(0, 255));
      fp = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 1));
      send(1, d, fp);
      expect_word(1, model(1, d, last_pbit, 1'b0), "par_rand");
    end

    // 7 bits, odd parity, 2 stops, 8x
    send(2, 9'h07F);
    expect_word(2, model(2, 9'h07F, last_pbit, 1'b0), "c_7f");
    for (int i = 0; i < 4; i++) begin
      d = 9'($urandom_range(0, 127));
      fp = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 1));
      send(2, d, fp);
      expect_word(2, model(2, d, last_pbit, 1'b0), "c_rand");
    end
    send(2, 9'h015, -1, 1'b1);
    expect_word(2, model(2, 9'h015, last_pbit, 1'b1), "c_stop2_low");
    tick(16);

    // overrun
    if_a.out_ready = 1'b0;
    ovr_a = 0;
    send(0, 9'h011);
    send(0, 9'h022);
    tick(20);
    chk("ovr_valid", 32'(if_a.out_valid), 32'd1);
    chk("ovr_out", 32'(if_a.out), 32'h11);
    chk("ovr_pulses", 32'(ovr_a), 32'd1);
    if_a.out_ready = 1'b1;
    tick();
    chk("ovr_drop", 32'(if_a.out_valid), 32'd0);
    expect_word(0, model(0, 9'h011, 1'b0, 1'b0), "ovr_word");

    // async reset mid-frame with a held word
    if_a.out_ready = 1'b0;
    send(0, 9'h066);
    tick(5);
    chk("pre_rst_valid", 32'(if_a.out_valid), 32'd1);
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 16);
    hold(0, 1'b0, 16);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_valid", 32'(if_a.out_valid), 32'd0);
    chk("arst_out", 32'(if_a.out), 32'd0);
    tick();
    rst_n = 1'b1;
    line_a = 1'b1;
    if_a.out_ready = 1'b1;
    tick(40);
    chk("arst_noword", 32'(q_a.size()), 32'd0);

    // enable drop mid-frame
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 16);
    hold(0, 1'b1, 16);
    chk("pre_en_busy", 32'(busy_a), 32'd1);
    en = 1'b0;
    tick(3);
    chk("en_busy", 32'(busy_a), 32'd0);
    en = 1'b1;
    hold(0, 1'b1, 48);
    chk("en_noword", 32'(q_a.size()), 32'd0);
    send(0, 9'h03C);
    expect_word(0, model(0, 9'h03C, 1'b0, 1'b0), "en_3c");
    tick(20);
    chk("en_extra", 32'(q_a.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
